pwm_gen: RTL and testbench
==========================

Name: pwm_gen

Overview:
- Downstream consumer of the ramping throttle counter: takes its duty count and generates the ESC/motor PWM waveform.
- Duty and period are double-buffered. They are applied only at PWM period boundaries, so the output never glitches mid-period.
- A per-period strobe (cycle_o) is provided to pace the upstream ramp counter's enable.
- Run/stop sequencing always finishes the current period before the output is parked.

Parameters:
- WIDTH, 8, width of duty, period and tick counter.
- PRESCALE, 1, clocks per PWM count tick (legal range 1..65535).
- MIN_DUTY, 0, lower clamp applied to duty_i at load.
- MAX_DUTY, 2**WIDTH-1, upper clamp applied to duty_i at load (MIN_DUTY <= MAX_DUTY).

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- ena_i  in  1  run request (level).
- period_i  in  WIDTH  period length minus 1, in ticks.
- duty_i  in  WIDTH  requested high time in ticks (upstream count).
- pwm_o  out  1  PWM output.
- cycle_o  out  1  one-clock pulse at the start of each applied period.
- duty_q_o  out  WIDTH  duty currently applied (clamped shadow value).
- active_o  out  1  high while state != IDLE.

Behaviour:
- Single clock; rst_i is synchronous active-high and overrides all other inputs.
- Reset values: state=IDLE, cnt=0, pre=0, duty_q=0, period_q=0, cycle_o=0, pwm_o=0, active_o=0.
- States: IDLE, RUN, STOP.
- IDLE:
  - pwm_o=0; cnt and pre held at 0.
  - On an edge with ena_i=1: state<=RUN, cnt<=0, pre<=0, period_q<=period_i, duty_q<=clamp(duty_i), cycle_o<=1.
  - The first RUN cycle is therefore also cycle 0 of the first period.
- Prescaler (RUN/STOP only):
  - pre counts 0..PRESCALE-1 and wraps.
  - tick = (pre==PRESCALE-1). With PRESCALE=1, tick is asserted every clock.
- Period counter, on tick:
  - If cnt==period_q: period end, cnt<=0.
  - Otherwise: cnt<=cnt+1.
- Period end in RUN: period_q<=period_i, duty_q<=clamp(duty_i), cycle_o<=1 for one clock. This is the only point where shadows reload.
- Period end in STOP: state<=IDLE, no reload, no cycle_o pulse.
- cycle_o is 0 in all other cycles.
- ena_i=0 in RUN: state<=STOP on the next edge. Counting continues and the current period completes normally.
- ena_i=1 in STOP: state<=RUN, with no restart or reset of cnt/pre.
- pwm_o = (state!=IDLE) && (cnt < duty_q):
  - Combinational decode of registered cnt and duty_q only.
  - High for the first duty_q ticks of each period.
- clamp(x) = min(max(x, MIN_DUTY), MAX_DUTY), unsigned compare.
- Boundary cases:
  - duty_q=0: pwm_o constant 0.
  - duty_q>period_q: pwm_o constant 1 for the whole period (100%).
  - period_q=0: 1-tick period, cnt stays 0, pwm_o = (duty_q>=1), cycle_o pulses every tick-period.
  - duty_i/period_i changes mid-period: no effect until the next period end.
- Period in clocks = (period_q+1)*PRESCALE.
- duty_q_o = duty_q; active_o = (state!=IDLE).
- Reset mid-operation: the next cycle shows reset values regardless of ena_i. If ena_i is held high, the first RUN entry is on the first edge after rst_i deasserts.

Test Plan:
- PRESCALE=1, rst_i released, ena_i=1, period_i=9, duty_i=3 -> cycle_o pulses every 10 clocks beginning the cycle after the IDLE->RUN edge; pwm_o high 3 clocks then low 7, repeating; duty_q_o=3.
- Same setup, duty_i 3->7 at cnt=4 -> current period stays 3 high; next period (after cycle_o) 7 high/3 low; duty_q_o updates in the same cycle cycle_o rises.
- period_i=9 with duty_i=0 -> pwm_o constant 0; duty_i=10 -> constant 1; with MAX_DUTY=150, duty_i=200 -> duty_q_o=150; with MIN_DUTY=20, duty_i=5 -> duty_q_o=20.
- ena_i dropped at cnt=5 (period_i=9, duty_i=3) -> active_o stays 1 through cnt=9; IDLE at wrap, pwm_o=0, no cycle_o pulse. Repeat with ena_i re-raised at cnt=7 -> period wraps normally with cycle_o, active_o never drops.
- PRESCALE=4, period_i=9, duty_i=3 -> pwm_o high 12 clocks, low 28; cycle_o every 40 clocks.
- rst_i asserted for 1 clock at cnt=5 with ena_i=1 -> following cycle all outputs at reset values; RUN re-entered on the first edge after release, cycle_o pulse, cnt=0.

Source files
------------

// File: rtl/pwm_gen.sv
// Double-buffered PWM generator with prescaled tick, per-period strobe and
// run/stop sequencing that always completes the current period before parking.
module pwm_gen #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned MIN_DUTY = 0,
    parameter int unsigned MAX_DUTY = (1 << WIDTH) - 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ena_i,
    input  logic [WIDTH-1:0] period_i,
    input  logic [WIDTH-1:0] duty_i,
    output logic             pwm_o,
    output logic             cycle_o,
    output logic [WIDTH-1:0] duty_q_o,
    output logic             active_o
);

    localparam int unsigned PRE_W = 16;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MIN_W    = WIDTH'(MIN_DUTY);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_DUTY);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             cycle_q, cycle_d;
    logic [WIDTH-1:0] duty_clamped_c;
    logic             tick_c;
    logic             period_end_c;

    // Duty is clamped on its way into the shadow register
    always_comb begin
        duty_clamped_c = duty_i;
        if (duty_i < MIN_W) begin
            duty_clamped_c = MIN_W;
        end else if (duty_i > MAX_W) begin
            duty_clamped_c = MAX_W;
        end
    end

    assign tick_c       = (pre_q == PRE_LAST);
    assign period_end_c = tick_c && (cnt_q == period_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        duty_d   = duty_q;
        period_d = period_q;
        cycle_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                pre_d = '0;
                if (ena_i) begin
                    state_d  = RUN;
                    period_d = period_i;
                    duty_d   = duty_clamped_c;
                    cycle_d  = 1'b1;
                end
            end
            RUN, STOP: begin
                pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
                if (tick_c) begin
                    cnt_d = period_end_c ? '0 : cnt_q + WIDTH'(1);
                end
                if (state_q == RUN) begin
                    if (period_end_c) begin
                        period_d = period_i;
                        duty_d   = duty_clamped_c;
                        cycle_d  = 1'b1;
                    end
                    if (!ena_i) begin
                        state_d = STOP;
                    end
                end else begin
                    // A stop only parks at a period boundary
                    if (period_end_c) begin
                        state_d = IDLE;
                    end else if (ena_i) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pre_q    <= '0;
            duty_q   <= '0;
            period_q <= '0;
            cycle_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            duty_q   <= duty_d;
            period_q <= period_d;
            cycle_q  <= cycle_d;
        end
    end

    assign pwm_o    = (state_q != IDLE) && (cnt_q < duty_q);
    assign cycle_o  = cycle_q;
    assign duty_q_o = duty_q;
    assign active_o = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: default, clamped and prescaled instances share stimulus.
module tb_pwm_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] period;
    logic [7:0] duty;

    logic       pwm0, cyc0, act0;
    logic [7:0] dq0;
    logic       pwmc, cycc, actc;
    logic [7:0] dqc;
    logic       pwmp, cycp, actp;
    logic [7:0] dqp;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pwm_gen #(.WIDTH(8), .PRESCALE(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .period_i(period), .duty_i(duty),
        .pwm_o(pwm0), .cycle_o(cyc0), .duty_q_o(dq0), .active_o(act0));

    pwm_gen #(.WIDTH(8), .PRESCALE(1), .MIN_DUTY(20), .MAX_DUTY(150)) dutc (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .period_i(period), .duty_i(duty),
        .pwm_o(pwmc), .cycle_o(cycc), .duty_q_o(dqc), .active_o(actc));

    pwm_gen #(.WIDTH(8), .PRESCALE(4)) dutp (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .period_i(period), .duty_i(duty),
        .pwm_o(pwmp), .cycle_o(cycp), .duty_q_o(dqp), .active_o(actp));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset one clock, then request run; the next edge enters RUN (sample k=0)
    task automatic start(input logic [7:0] p, input logic [7:0] d);
        rst = 1'b1; ena = 1'b0;
        step();
        rst = 1'b0; ena = 1'b1; period = p; duty = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; period = 8'd9; duty = 8'd3;
        step(); step();
        tests++;
        if ({pwm0, cyc0, act0, dq0} !== 11'd0) begin
            fails++; $display("FAIL reset_dut0 got=%b exp=0", {pwm0, cyc0, act0, dq0});
        end
        tests++;
        if ({pwmp, cycp, actp, dqp, pwmc, cycc, actc, dqc} !== 22'd0) begin
            fails++; $display("FAIL reset_others got=%b exp=0",
                              {pwmp, cycp, actp, dqp, pwmc, cycc, actc, dqc});
        end
    endtask

    task automatic test_basic();
        start(8'd9, 8'd3);
        for (int k = 0; k < 30; k++) begin
            step();
            tests++;
            if (cyc0 !== ((k % 10) == 0)) begin
                fails++; $display("FAIL basic_cycle k=%0d got=%b exp=%b", k, cyc0, (k % 10) == 0);
            end
            tests++;
            if (pwm0 !== ((k % 10) < 3)) begin
                fails++; $display("FAIL basic_pwm k=%0d got=%b exp=%b", k, pwm0, (k % 10) < 3);
            end
            tests++;
            if (dq0 !== 8'd3 || act0 !== 1'b1) begin
                fails++; $display("FAIL basic_duty k=%0d got=%0d/%b exp=3/1", k, dq0, act0);
            end
        end
    endtask

    task automatic test_duty_change();
        start(8'd9, 8'd3);
        for (int k = 0; k < 20; k++) begin
            logic       exp_pwm;
            logic [7:0] exp_dq;
            step();
            exp_dq  = (k < 10) ? 8'd3 : 8'd7;
            exp_pwm = (k < 10) ? ((k % 10) < 3) : ((k % 10) < 7);
            tests++;
            if (pwm0 !== exp_pwm || dq0 !== exp_dq || cyc0 !== ((k % 10) == 0)) begin
                fails++; $display("FAIL duty_change k=%0d got=%b/%0d/%b exp=%b/%0d/%b",
                                  k, pwm0, dq0, cyc0, exp_pwm, exp_dq, (k % 10) == 0);
            end
            if (k == 4) duty = 8'd7;
        end
    endtask

    task automatic test_boundaries();
        start(8'd9, 8'd0);
        for (int k = 0; k < 20; k++) begin
            step();
            tests++;
            if (pwm0 !== 1'b0) begin
                fails++; $display("FAIL duty0 k=%0d got=%b exp=0", k, pwm0);
            end
        end
        start(8'd9, 8'd10);
        for (int k = 0; k < 20; k++) begin
            step();
            tests++;
            if (pwm0 !== 1'b1) begin
                fails++; $display("FAIL duty100 k=%0d got=%b exp=1", k, pwm0);
            end
        end
        start(8'd9, 8'd200);
        step();
        tests++;
        if (dqc !== 8'd150 || dq0 !== 8'd200) begin
            fails++; $display("FAIL clamp_max got=%0d/%0d exp=150/200", dqc, dq0);
        end
        start(8'd9, 8'd5);
        step();
        tests++;
        if (dqc !== 8'd20 || dq0 !== 8'd5) begin
            fails++; $display("FAIL clamp_min got=%0d/%0d exp=20/5", dqc, dq0);
        end
        start(8'd0, 8'd1);
        for (int k = 0; k < 6; k++) begin
            step();
            tests++;
            if (cyc0 !== 1'b1 || pwm0 !== 1'b1) begin
                fails++; $display("FAIL period0 k=%0d got=%b%b exp=11", k, cyc0, pwm0);
            end
        end
    endtask

    task automatic test_stop(input bit reraise);
        start(8'd9, 8'd3);
        for (int k = 0; k < 16; k++) begin
            logic exp_act, exp_pwm, exp_cyc;
            step();
            exp_act = reraise || (k < 10);
            exp_pwm = exp_act && ((k % 10) < 3);
            exp_cyc = reraise ? ((k % 10) == 0) : (k == 0);
            tests++;
            if (act0 !== exp_act || pwm0 !== exp_pwm || cyc0 !== exp_cyc) begin
                fails++; $display("FAIL stop%0d k=%0d got=%b%b%b exp=%b%b%b", reraise, k,
                                  act0, pwm0, cyc0, exp_act, exp_pwm, exp_cyc);
            end
            if (k == 5) ena = 1'b0;
            if (k == 7 && reraise) ena = 1'b1;
        end
    endtask

    task automatic test_prescale();
        start(8'd9, 8'd3);
        for (int k = 0; k < 80; k++) begin
            step();
            tests++;
            if (pwmp !== ((k % 40) < 12) || cycp !== ((k % 40) == 0)) begin
                fails++; $display("FAIL prescale k=%0d got=%b%b exp=%b%b", k, pwmp, cycp,
                                  (k % 40) < 12, (k % 40) == 0);
            end
        end
    endtask

    task automatic test_mid_reset();
        start(8'd9, 8'd3);
        for (int k = 0; k < 6; k++) step();
        rst = 1'b1;
        step();
        tests++;
        if ({pwm0, cyc0, act0, dq0} !== 11'd0) begin
            fails++; $display("FAIL midreset got=%b exp=0", {pwm0, cyc0, act0, dq0});
        end
        rst = 1'b0;
        step();
        tests++;
        if ({pwm0, cyc0, act0, dq0} !== {3'b111, 8'd3}) begin
            fails++; $display("FAIL reentry got=%b exp=%b", {pwm0, cyc0, act0, dq0}, {3'b111, 8'd3});
        end
        step();
        tests++;
        if (cyc0 !== 1'b0 || pwm0 !== 1'b1) begin
            fails++; $display("FAIL reentry_next got=%b%b exp=01", cyc0, pwm0);
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; period = '0; duty = '0;
        test_reset();
        test_basic();
        test_duty_change();
        test_boundaries();
        test_stop(1'b0);
        test_stop(1'b1);
        test_prescale();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
